// File: rtl/sine_envelope_shaper.sv
// Decimates the DDS sine to the audio rate, applies a linear attack/sustain/decay
// envelope and hands the scaled samples downstream over valid/ready.
module sine_envelope_shaper #(
    parameter int unsigned SAMPLE_DIV = 1042,
    parameter logic [15:0] AMP_MAX    = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sine_in,
    input  logic        start,
    input  logic [15:0] attack_step,
    input  logic [15:0] decay_step,
    input  logic [15:0] sustain_samples,
    input  logic        out_ready,
    output logic [15:0] out_sample,
    output logic        out_valid,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(SAMPLE_DIV);

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, DECAY} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] amp_q, amp_d;
    logic [15:0] sus_q, sus_d;
    logic        done_q, done_d;

    logic        cap_vld_q, cap_vld_d;
    logic [15:0] cap_sine_q, cap_sine_d;
    logic [15:0] cap_amp_q, cap_amp_d;
    logic        prod_vld_q, prod_vld_d;
    logic [15:0] prod_q, prod_d;

    logic [15:0] out_sample_q, out_sample_d;
    logic        out_valid_q, out_valid_d;
    logic        overflow_q, overflow_d;

    logic        tick;
    logic        start_accept;
    logic [16:0] attack_sum;
    logic signed [32:0] mul_a, mul_b;

    assign tick         = (cnt_q == CW'(SAMPLE_DIV - 1));
    assign start_accept = start && (state_q == IDLE);
    assign attack_sum   = {1'b0, amp_q} + {1'b0, attack_step};

    assign mul_a = {{17{cap_sine_q[15]}}, cap_sine_q};
    assign mul_b = {17'd0, cap_amp_q};

    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        cap_vld_d    = tick;
        cap_sine_d   = tick ? sine_in : cap_sine_q;
        cap_amp_d    = tick ? amp_q : cap_amp_q;
        prod_vld_d   = cap_vld_q;
        // Only product[31:16] is ever consumed, so the register holds that slice of the 33-bit product.
        prod_d       = cap_vld_q ? 16'((mul_a * mul_b) >>> 16) : prod_q;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        overflow_d   = overflow_q;
        if (start_accept) begin
            overflow_d = 1'b0;
        end
        if (prod_vld_q) begin
            if (out_valid_q && !out_ready) begin
                overflow_d = 1'b1;
            end else begin
                out_sample_d = prod_q;
                out_valid_d  = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        sus_d   = sus_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ATTACK;
                end
            end
            ATTACK: begin
                if (tick) begin
                    if ((attack_step == '0) || (attack_sum >= {1'b0, AMP_MAX})) begin
                        amp_d   = AMP_MAX;
                        state_d = SUSTAIN;
                        sus_d   = sustain_samples;
                    end else begin
                        amp_d = attack_sum[15:0];
                    end
                end
            end
            SUSTAIN: begin
                if (tick) begin
                    if (sus_q <= 16'd1) begin
                        state_d = DECAY;
                    end else begin
                        sus_d = sus_q - 16'd1;
                    end
                end
            end
            DECAY: begin
                if (tick) begin
                    if ((decay_step == '0) || (decay_step >= amp_q)) begin
                        amp_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        amp_d = amp_q - decay_step;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            amp_q        <= '0;
            sus_q        <= '0;
            done_q       <= 1'b0;
            cap_vld_q    <= 1'b0;
            cap_sine_q   <= '0;
            cap_amp_q    <= '0;
            prod_vld_q   <= 1'b0;
            prod_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            amp_q        <= amp_d;
            sus_q        <= sus_d;
            done_q       <= done_d;
            cap_vld_q    <= cap_vld_d;
            cap_sine_q   <= cap_sine_d;
            cap_amp_q    <= cap_amp_d;
            prod_vld_q   <= prod_vld_d;
            prod_q       <= prod_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule
